// File: rtl/clkgen_multi_pkg.sv
`default_nettype none
//==============================================================================
// Module   : clkgen_pkg
// Brief    : Shared types and the config-write validity check for clkgen_multi.
// Revision : 1.0 - initial release
//==============================================================================
package clkgen_pkg;

    // Channel config fields are carried at this width; CNT_W must not exceed it.
    localparam int c_CNT_W_MAX = 16;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    typedef struct packed {
        logic [c_CNT_W_MAX-1:0] div;
        logic [c_CNT_W_MAX-1:0] high;
        logic [c_CNT_W_MAX-1:0] phase;
    } chan_cfg_t;

    function automatic logic cfg_is_valid(
        input logic [2:0]             ch,
        input logic [c_CNT_W_MAX-1:0] div,
        input logic [c_CNT_W_MAX-1:0] high,
        input logic [c_CNT_W_MAX-1:0] phase,
        input int                     num_clk
    );
        return ({29'd0, ch} < num_clk)
            && (div >= c_CNT_W_MAX'(2))
            && (high >= c_CNT_W_MAX'(1))
            && (high < div)
            && (phase < div);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clkgen_multi_if.sv
`default_nettype none
//==============================================================================
// Module   : clkgen_multi_if
// Brief    : Valid/ready configuration write port of clkgen_multi.
// Revision : 1.0 - initial release
//==============================================================================
interface clkgen_multi_if #(
    parameter int CNT_W = 16
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [2:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;
    logic [CNT_W-1:0] cfg_phase;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase,
        output cfg_ready, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/clkgen_multi_chan.sv
`default_nettype none
//==============================================================================
// Module   : clkgen_chan
// Brief    : One divided-clock channel: phase-load on align, free-run on run.
// Revision : 1.0 - initial release
//==============================================================================
module clkgen_chan
    import clkgen_pkg::*;
(
    input  logic      refclk,
    input  logic      rst,
    input  logic      align,
    input  logic      run,
    input  chan_cfg_t cfg,
    output logic      outclk,
    output logic      outclk_en
);

    logic [c_CNT_W_MAX-1:0] r_cnt;
    logic [c_CNT_W_MAX-1:0] w_load;
    logic [c_CNT_W_MAX-1:0] w_next;
    logic [c_CNT_W_MAX-1:0] w_tgt;

    // Loading div-phase makes the count reach 0 exactly `phase` cycles after align.
    assign w_load = (cfg.phase == '0) ? '0 : cfg.div - cfg.phase;
    assign w_next = (r_cnt >= cfg.div - c_CNT_W_MAX'(1)) ? '0 : r_cnt + c_CNT_W_MAX'(1);
    assign w_tgt  = align ? w_load : w_next;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            outclk    <= 1'b0;
            outclk_en <= 1'b0;
        end else if (align || run) begin
            r_cnt     <= w_tgt;
            outclk    <= (w_tgt < cfg.high);
            outclk_en <= (w_tgt == '0);
        end else begin
            outclk    <= 1'b0;
            outclk_en <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clkgen_multi.sv
`default_nettype none
//==============================================================================
// Module   : clkgen_multi
// Brief    : NUM_CLK run-time configurable integer clock dividers with lock flag.
// Revision : 1.0 - initial release
//==============================================================================
module clkgen_multi
    import clkgen_pkg::*;
#(
    parameter int NUM_CLK      = 2,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_DIV  = 5,
    parameter int DEFAULT_HIGH = 3,
    parameter int LOCK_CYCLES  = 16
) (
    input  logic               refclk,
    input  logic               rst,
    clkgen_multi_if.slave      cfg,
    output logic [NUM_CLK-1:0] outclk,
    output logic [NUM_CLK-1:0] outclk_en,
    output logic               locked
);

    localparam int c_SW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    state_t           r_state;
    logic [c_SW-1:0]  r_settle_cnt;
    logic             r_ready;
    logic             r_err;
    logic             r_locked;
    logic [CNT_W-1:0] r_div   [NUM_CLK];
    logic [CNT_W-1:0] r_high  [NUM_CLK];
    logic [CNT_W-1:0] r_phase [NUM_CLK];

    logic w_accept;
    logic w_ok;
    logic w_wr;
    logic w_bad;
    logic w_last;
    logic w_align;
    logic w_run;

    assign w_accept = cfg.cfg_valid && r_ready;
    assign w_ok     = cfg_is_valid(cfg.cfg_ch,
                                   c_CNT_W_MAX'(cfg.cfg_div),
                                   c_CNT_W_MAX'(cfg.cfg_high),
                                   c_CNT_W_MAX'(cfg.cfg_phase),
                                   NUM_CLK);
    assign w_wr     = w_accept && w_ok;
    assign w_bad    = w_accept && !w_ok;

    // Settling only starts once the port is ready, so cycle 0 holds count 0.
    assign w_last  = (r_state == SETTLE) && r_ready
                  && (r_settle_cnt == c_SW'(LOCK_CYCLES - 1));
    assign w_align = w_last && !w_wr;
    assign w_run   = (r_state == RUN) && !w_wr;

    assign cfg.cfg_ready = r_ready;
    assign cfg.cfg_err   = r_err;
    assign locked        = r_locked;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state      <= SETTLE;
            r_settle_cnt <= '0;
            r_ready      <= 1'b0;
            r_err        <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            r_err   <= w_bad;
            if (w_wr) begin
                r_state      <= SETTLE;
                r_settle_cnt <= '0;
                r_locked     <= 1'b0;
            end else begin
                case (r_state)
                    SETTLE: begin
                        if (w_align) begin
                            r_state      <= RUN;
                            r_settle_cnt <= '0;
                            r_locked     <= 1'b1;
                        end else if (r_ready) begin
                            r_settle_cnt <= r_settle_cnt + c_SW'(1);
                        end
                    end
                    RUN:     r_locked <= 1'b1;
                    default: r_state  <= SETTLE;
                endcase
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLK; i++) begin
                r_div[i]   <= CNT_W'(DEFAULT_DIV);
                r_high[i]  <= CNT_W'(DEFAULT_HIGH);
                r_phase[i] <= '0;
            end
        end else if (w_wr) begin
            for (int i = 0; i < NUM_CLK; i++) begin
                if (cfg.cfg_ch == 3'(i)) begin
                    r_div[i]   <= cfg.cfg_div;
                    r_high[i]  <= cfg.cfg_high;
                    r_phase[i] <= cfg.cfg_phase;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CLK; gi++) begin : g_chan
        chan_cfg_t w_cfg;

        assign w_cfg = '{div:   c_CNT_W_MAX'(r_div[gi]),
                         high:  c_CNT_W_MAX'(r_high[gi]),
                         phase: c_CNT_W_MAX'(r_phase[gi])};

        clkgen_chan u_chan (
            .refclk    (refclk),
            .rst       (rst),
            .align     (w_align),
            .run       (w_run),
            .cfg       (w_cfg),
            .outclk    (outclk[gi]),
            .outclk_en (outclk_en[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clkgen_multi.sv
`default_nettype none
//==============================================================================
// Module   : tb_clkgen_multi
// Brief    : Self-checking bench for clkgen_multi (2-channel and degenerate builds).
// Revision : 1.0 - initial release
//==============================================================================
module tb_clkgen_multi;

    localparam int LC = 16;

    logic refclk = 1'b0;
    logic rst    = 1'b1;
    always #5 refclk = ~refclk;

    clkgen_multi_if #(.CNT_W(16)) cfg_if  ();
    clkgen_multi_if #(.CNT_W(16)) cfg_if2 ();

    logic [1:0] outclk, outclk_en;
    logic       locked;
    logic [0:0] outclk2, outclk_en2;
    logic       locked2;

    clkgen_multi #(
        .NUM_CLK(2), .CNT_W(16), .DEFAULT_DIV(5), .DEFAULT_HIGH(3), .LOCK_CYCLES(LC)
    ) dut (
        .refclk(refclk), .rst(rst), .cfg(cfg_if),
        .outclk(outclk), .outclk_en(outclk_en), .locked(locked)
    );

    clkgen_multi #(
        .NUM_CLK(1), .CNT_W(16), .DEFAULT_DIV(2), .DEFAULT_HIGH(1), .LOCK_CYCLES(1)
    ) dut2 (
        .refclk(refclk), .rst(rst), .cfg(cfg_if2),
        .outclk(outclk2), .outclk_en(outclk_en2), .locked(locked2)
    );

    int checks   = 0;
    int failures = 0;
    int n        = -1;     // index of the most recent refclk edge since reset release
    int lock_edge = LC;    // edge at which locked is expected to rise
    int m_div   [2] = '{5, 5};
    int m_high  [2] = '{3, 3};
    int m_phase [2] = '{0, 0};
    bit drv_ok = 1'b0;     // hand-marked validity of the write being driven

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Ideal waveform: a div-periodic pulse train of width `high`, shifted by `ph` from lock.
    function automatic void wave(input int cyc, input int le, input int dv, input int hi,
                                 input int ph, output bit oc, output bit en);
        int m;
        if (cyc < le) begin
            oc = 1'b0;
            en = 1'b0;
        end else begin
            m  = (cyc - le + dv - ph) % dv;
            oc = (m < hi);
            en = (m == 0);
        end
    endfunction

    always @(posedge refclk) begin
        bit       err_exp;
        bit [1:0] oc, en;
        bit       o2, e2;
        int       idx;
        if (rst) begin
            n         = -1;
            lock_edge = LC;
            for (int i = 0; i < 2; i++) begin
                m_div[i]   = 5;
                m_high[i]  = 3;
                m_phase[i] = 0;
            end
        end else begin
            n       = n + 1;
            err_exp = 1'b0;
            if (n >= 1 && cfg_if.cfg_valid) begin
                if (drv_ok) begin
                    idx          = int'(cfg_if.cfg_ch);
                    m_div[idx]   = int'(cfg_if.cfg_div);
                    m_high[idx]  = int'(cfg_if.cfg_high);
                    m_phase[idx] = int'(cfg_if.cfg_phase);
                    lock_edge    = n + LC;
                end else begin
                    err_exp = 1'b1;
                end
            end
            #1;
            if (!rst) begin
                for (int i = 0; i < 2; i++) begin
                    bit a, b;
                    wave(n, lock_edge, m_div[i], m_high[i], m_phase[i], a, b);
                    oc[i] = a;
                    en[i] = b;
                end
                wave(n, 1, 2, 1, 0, o2, e2);
                check($sformatf("locked@%0d", n),     locked,           n >= lock_edge);
                check($sformatf("outclk@%0d", n),     outclk,           oc);
                check($sformatf("outclk_en@%0d", n),  outclk_en,        en);
                check($sformatf("cfg_err@%0d", n),    cfg_if.cfg_err,   err_exp);
                check($sformatf("cfg_ready@%0d", n),  cfg_if.cfg_ready, 1'b1);
                check($sformatf("locked2@%0d", n),    locked2,          n >= 1);
                check($sformatf("outclk2@%0d", n),    outclk2,          o2);
                check($sformatf("outclk_en2@%0d", n), outclk_en2,       e2);
            end
        end
    end

    task automatic to_cycle(input int k);
        int guard = 0;
        while (n < k && guard < 1000) begin
            @(negedge refclk);
            guard++;
        end
        checks++;
        if (n != k) begin
            failures++;
            $display("FAIL to_cycle actual=%0d required=%0d", n, k);
        end
    endtask

    task automatic do_write(input int ch, input int dv, input int hi, input int ph, input bit ok);
        cfg_if.cfg_ch    = 3'(ch);
        cfg_if.cfg_div   = 16'(dv);
        cfg_if.cfg_high  = 16'(hi);
        cfg_if.cfg_phase = 16'(ph);
        drv_ok           = ok;
        cfg_if.cfg_valid = 1'b1;
        @(negedge refclk);
        cfg_if.cfg_valid = 1'b0;
        drv_ok           = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_ch     = '0;
        cfg_if.cfg_div    = '0;
        cfg_if.cfg_high   = '0;
        cfg_if.cfg_phase  = '0;
        cfg_if2.cfg_valid = 1'b0;
        cfg_if2.cfg_ch    = '0;
        cfg_if2.cfg_div   = '0;
        cfg_if2.cfg_high  = '0;
        cfg_if2.cfg_phase = '0;

        #2;
        check("rst_locked", locked, 1'b0);
        check("rst_outclk", outclk, 2'b00);
        check("rst_outclk_en", outclk_en, 2'b00);
        check("rst_ready", cfg_if.cfg_ready, 1'b0);
        check("rst_err", cfg_if.cfg_err, 1'b0);
        check("rst_locked2", locked2, 1'b0);
        @(negedge refclk);
        @(negedge refclk);
        rst = 1'b0;

        // Default lock and waveform
        to_cycle(0);  check("c0_ready", cfg_if.cfg_ready, 1'b1);
                      check("c0_locked", locked, 1'b0);
        to_cycle(1);  check("d2_lock", locked2, 1'b1);
                      check("d2_c1", outclk2, 1'b1);
        to_cycle(2);  check("d2_c2", outclk2, 1'b0);
        to_cycle(3);  check("d2_c3", outclk2, 1'b1);
        to_cycle(15); check("c15_locked", locked, 1'b0);
        to_cycle(16); check("c16_locked", locked, 1'b1);
                      check("c16_outclk", outclk, 2'b11);
                      check("c16_en", outclk_en, 2'b11);
        to_cycle(17); check("c17_en", outclk_en, 2'b00);
        to_cycle(19); check("c19_outclk", outclk, 2'b00);
        to_cycle(21); check("c21_outclk", outclk, 2'b11);
                      check("c21_en", outclk_en, 2'b11);

        // Phase write on ch1
        to_cycle(30); do_write(1, 4, 2, 1, 1'b1);
        check("w1_unlock", locked, 1'b0);
        check("w1_outclk", outclk, 2'b00);
        to_cycle(46); check("c46_locked", locked, 1'b0);
        to_cycle(47); check("c47_locked", locked, 1'b1);
                      check("c47_outclk", outclk, 2'b01);
                      check("c47_en", outclk_en, 2'b01);
        to_cycle(48); check("c48_outclk", outclk, 2'b11);
                      check("c48_en", outclk_en, 2'b10);
        to_cycle(50); check("c50_outclk", outclk, 2'b00);
        to_cycle(52); check("c52_en", outclk_en, 2'b11);

        // Invalid writes
        to_cycle(60); do_write(0, 4, 4, 0, 1'b0);
        check("bad1_err", cfg_if.cfg_err, 1'b1);
        check("bad1_locked", locked, 1'b1);
        to_cycle(62); check("bad1_err_off", cfg_if.cfg_err, 1'b0);
        to_cycle(64); do_write(5, 4, 2, 0, 1'b0);
        check("bad2_err", cfg_if.cfg_err, 1'b1);
        check("bad2_locked", locked, 1'b1);
        to_cycle(66); check("bad2_err_off", cfg_if.cfg_err, 1'b0);

        // Write landing on the final settle count
        to_cycle(70); do_write(0, 6, 3, 2, 1'b1);
        to_cycle(86); do_write(1, 3, 1, 2, 1'b1);
        check("c87_locked", locked, 1'b0);
        to_cycle(102); check("c102_locked", locked, 1'b0);
        to_cycle(103); check("c103_locked", locked, 1'b1);
                       check("c103_outclk", outclk, 2'b00);
        to_cycle(105); check("c105_outclk", outclk, 2'b11);
                       check("c105_en", outclk_en, 2'b11);

        // Asynchronous reset in RUN
        to_cycle(110); check("c110_locked", locked, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_locked", locked, 1'b0);
        check("arst_outclk", outclk, 2'b00);
        check("arst_en", outclk_en, 2'b00);
        check("arst_ready", cfg_if.cfg_ready, 1'b0);
        check("arst_locked2", locked2, 1'b0);
        check("arst_outclk2", outclk2, 1'b0);
        @(negedge refclk);
        rst = 1'b0;
        to_cycle(16); check("r16_locked", locked, 1'b1);
                      check("r16_outclk", outclk, 2'b11);
        to_cycle(19); check("r19_outclk", outclk, 2'b00);
        to_cycle(21); check("r21_outclk", outclk, 2'b11);
                      check("r21_en", outclk_en, 2'b11);
        to_cycle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clkgen_multi.md
# clkgen_multi

Parametrised multi-output digital clock generator. From the single board reference clock, it derives NUM_CLK integer-divided clock outputs. Each output has its own divide ratio, high time and phase offset, and each can be reconfigured at run time through a valid/ready write port. A `locked` flag indicates that all outputs are phase-aligned and stable. It is the fabric-logic successor to the single-output fixed-frequency PLL wrapper. It sits at the top level and feeds `outclk`/`outclk_en` to slow peripherals.

## Interface
Parameters:
- NUM_CLK, 2: number of output channels, range 1..8.
- CNT_W, 16: width of divide/high/phase fields.
- DEFAULT_DIV, 5: reset divide ratio for every channel (50 MHz to 10 MHz).
- DEFAULT_HIGH, 3: reset high time, in refclk cycles.
- LOCK_CYCLES, 16: settle time before `locked` asserts, at least 1.

Ports:
- refclk, in, 1: sole clock; all logic is on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- cfg_valid, in, 1: configuration write request.
- cfg_ready, out, 1: write port can accept.
- cfg_ch, in, 3: target channel.
- cfg_div, in, CNT_W: divide ratio.
- cfg_high, in, CNT_W: high time in cycles.
- cfg_phase, in, CNT_W: delay of the first rising edge after alignment, in cycles.
- cfg_err, out, 1: one-cycle pulse when a write is rejected.
- outclk, out, NUM_CLK: registered divided clocks.
- outclk_en, out, NUM_CLK: one-cycle pulse in the cycle each outclk rises.
- locked, out, 1: all channels aligned and running.

## Operation
- The FSM has two states: SETTLE and RUN. Reset enters SETTLE.
- **SETTLE**
  - Settle counter counts 0..LOCK_CYCLES-1.
  - `outclk` = 0, `outclk_en` = 0, `locked` = 0.
  - On the last count, go to RUN.
  - On entry to RUN, every channel counter loads L = (phase==0) ? 0 : div-phase.
- **RUN**
  - Each channel counter counts 0..div-1, then wraps to 0.
  - `outclk[i]` is registered from (next_cnt < high).
  - `outclk_en[i]` is registered from (next_cnt == 0).
  - `locked` = 1.
- **Config writes**
  - `cfg_ready` = 1 in both SETTLE and RUN; it is 0 only during reset.
  - A write is accepted when `cfg_valid && cfg_ready`.
- **Validity**: a write is valid if cfg_ch < NUM_CLK, cfg_div ≥ 2, 1 ≤ cfg_high < cfg_div, and cfg_phase < cfg_div.
- **Invalid write**: `cfg_err` pulses high on the next cycle. Channel registers, state and `locked` are unchanged.
- **Valid write**:
  - The channel's div/high/phase registers update.
  - Next cycle: state becomes SETTLE, the settle counter clears, `locked`, `outclk` and `outclk_en` go to 0.
  - All channels (not just the target channel) realign when RUN is re-entered.
- **Write in the same cycle as the last settle count**: the write wins. The block stays in SETTLE, the settle counter restarts, and `locked` remains 0.
- **Reset mid-operation**: all outputs go to 0 asynchronously and the channel registers reload their defaults. Default phase is 0.

## Timing
- **Reset values**:
  - `outclk` = 0, `outclk_en` = 0, `locked` = 0, `cfg_ready` = 0, `cfg_err` = 0.
  - All channels reload div = DEFAULT_DIV, high = DEFAULT_HIGH, phase = 0.
- **After reset release**: the first refclk edge is cycle 0, and `cfg_ready` = 1 from cycle 0.
- **Lock**: `locked` rises at the edge of cycle LOCK_CYCLES. On that same edge, channels with phase = 0 raise `outclk` and `outclk_en`.
- **Phase offset**: a channel with phase p first rises p cycles after `locked`.
- **Steady-state waveform**: period = div cycles; high for `high` cycles, then low for div-high cycles.
- **Write latency**: `locked` falls 1 cycle after an accepted write and rises again LOCK_CYCLES cycles later.
- **Error latency**: `cfg_err` asserts 1 cycle after an invalid handshake.
- **Glitch-freedom**: all outputs are flop outputs, so there are no combinational glitches.

## Structure
- **Package `clkgen_pkg`** holds:
  - the state enum {SETTLE, RUN};
  - the channel-config struct {div, high, phase};
  - the `cfg_is_valid()` function.
- **Sub-module `clkgen_chan`**: one instance per channel, generated NUM_CLK times.
  - Inputs: `align` (load pulse), `run`, and the config struct.
  - Function: loads L on `align`, counts while `run` is high.
  - Outputs: registered `outclk` and `outclk_en`.
- **Top level** contains the FSM, the settle counter, the config register file and the validity check.

## Test plan
- **Reset defaults**: release reset with defaults → `locked` rises at cycle 16. Both outputs have period 5, high 3, low 2. `outclk_en` pulses every 5 cycles, aligned with the rising edge.
- **Phase write**: write ch1 with div=4, high=2, phase=1 → `locked` falls next cycle and rises 16 cycles later. ch0 rises on the same edge as `locked`; ch1 first rises 1 cycle later, then has period 4, 50% duty.
- **Invalid writes**: write high=4 with div=4, then ch=5 with NUM_CLK=2 → `cfg_err` pulses once per write. `locked` stays 1 and the waveforms are undisturbed.
- **Write on last settle cycle**: issue a valid write on the cycle of the final settle count → `locked` stays 0 and rises LOCK_CYCLES cycles after the write.
- **Reset mid-RUN**: assert `rst` in the middle of RUN → all outputs go to 0 immediately. After release, the defaults (div=5, high=3) are restored regardless of earlier writes.
- **Degenerate width**: set NUM_CLK=1, LOCK_CYCLES=1, div=2, high=1 → `locked` is high at cycle 1, and `outclk` toggles every cycle from that edge.
